// File: rtl/motor_startup_sequencer.sv
// BLDC startup: rotor align, open-loop forced-commutation ramp, then hall-locked closed loop with stall/invalid-hall fault.
// Latency: phase follows a raw hall change by 3 clks in CLOSED; no backpressure, all outputs registered.
module motor_startup_sequencer #(
  parameter int ALIGN_TICKS    = 2000,
  parameter int START_INTERVAL = 1024,
  parameter int MIN_INTERVAL   = 128,
  parameter int RAMP_STEP      = 32,
  parameter int STALL_TICKS    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run_req,
  input  logic       dir,
  input  logic [2:0] hs,
  input  logic       fault_clr,
  output logic [2:0] phase,
  output logic       drive_en,
  output logic [2:0] state,
  output logic       fault
);

  localparam int CNT_MAX = (ALIGN_TICKS > START_INTERVAL) ? ALIGN_TICKS : START_INTERVAL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STL_W   = $clog2(STALL_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_RAMP   = 3'd2,
    S_CLOSED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t           st;
  logic [2:0]       hs_m, hs_s, hs_p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] interval_nxt;
  logic [STL_W-1:0] stall_cnt;
  logic             dir_l;
  logic             hall_edge;
  logic             hall_bad;
  logic [2:0]       hall_phase;
  logic [2:0]       phase_step;

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_m <= 3'd0;
      hs_s <= 3'd0;
      hs_p <= 3'd0;
    end else begin
      hs_m <= hs;
      hs_s <= hs_m;
      hs_p <= hs_s;
    end
  end

  assign hall_edge = (hs_s != hs_p);
  assign hall_bad  = (hs_s == 3'd0) || (hs_s == 3'd7);

  function automatic logic [2:0] hall_map(input logic [2:0] h, input logic cw);
    logic [2:0] p;
    p = 3'd0;
    case (h)
      3'd1:    p = cw ? 3'd4 : 3'd1;
      3'd2:    p = cw ? 3'd0 : 3'd3;
      3'd3:    p = cw ? 3'd5 : 3'd2;
      3'd4:    p = cw ? 3'd2 : 3'd5;
      3'd5:    p = cw ? 3'd3 : 3'd0;
      3'd6:    p = cw ? 3'd1 : 3'd4;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

  assign hall_phase = hall_map(hs_s, dir_l);
  assign phase_step = dir_l ? ((phase == 3'd5) ? 3'd0 : phase + 3'd1)
                            : ((phase == 3'd0) ? 3'd5 : phase - 3'd1);

  // Signed compare so a step larger than the interval clamps instead of wrapping.
  always_comb begin
    interval_nxt = CNT_W'(MIN_INTERVAL);
    if (int'(interval) - RAMP_STEP > MIN_INTERVAL)
      interval_nxt = interval - CNT_W'(RAMP_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      phase     <= 3'd0;
      drive_en  <= 1'b0;
      fault     <= 1'b0;
      cnt       <= '0;
      interval  <= '0;
      stall_cnt <= '0;
      dir_l     <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          phase    <= 3'd0;
          drive_en <= 1'b0;
          fault    <= 1'b0;
          if (tick && run_req) begin
            st       <= S_ALIGN;
            drive_en <= 1'b1;
            dir_l    <= dir;
            cnt      <= '0;
          end
        end

        S_ALIGN: begin
          if (!run_req) begin
            st       <= S_IDLE;
            drive_en <= 1'b0;
            phase    <= 3'd0;
          end else if (tick) begin
            if (cnt == CNT_W'(ALIGN_TICKS - 1)) begin
              st       <= S_RAMP;
              cnt      <= '0;
              interval <= CNT_W'(START_INTERVAL);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_RAMP: begin
          if (hall_bad) begin
            st       <= S_FAULT;
            drive_en <= 1'b0;
            phase    <= 3'd0;
            fault    <= 1'b1;
          end else if (!run_req) begin
            st       <= S_IDLE;
            drive_en <= 1'b0;
            phase    <= 3'd0;
          end else if (hall_edge && interval == CNT_W'(MIN_INTERVAL)) begin
            st        <= S_CLOSED;
            phase     <= hall_phase;
            stall_cnt <= '0;
          end else if (tick) begin
            if (cnt == interval - CNT_W'(1)) begin
              cnt      <= '0;
              phase    <= phase_step;
              interval <= interval_nxt;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_CLOSED: begin
          if (hall_bad || (tick && !hall_edge && stall_cnt == STL_W'(STALL_TICKS - 1))) begin
            st       <= S_FAULT;
            drive_en <= 1'b0;
            phase    <= 3'd0;
            fault    <= 1'b1;
          end else if (!run_req) begin
            st       <= S_IDLE;
            drive_en <= 1'b0;
            phase    <= 3'd0;
          end else begin
            phase <= hall_phase;
            if (hall_edge)
              stall_cnt <= '0;
            else if (tick)
              stall_cnt <= stall_cnt + STL_W'(1);
          end
        end

        S_FAULT: begin
          drive_en <= 1'b0;
          phase    <= 3'd0;
          fault    <= 1'b1;
          if (fault_clr && !run_req) begin
            st    <= S_IDLE;
            fault <= 1'b0;
          end
        end

        default: begin
          st       <= S_IDLE;
          drive_en <= 1'b0;
          phase    <= 3'd0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule
